surf_layer_sched: RTL and testbench

- Scheduler for the SURF determinant engine: runs the engine once per enabled scale layer, with filter size 9, 15, 21 or 27.
- Drives per-layer configuration, the engine go/done handshake and a watchdog.
- Relocates engine output writes into a per-layer region of the shared determinant memory.
- Sits between the host control registers and the engine, and owns the determinant-memory write port.

---
 rtl/surf_pkg.sv | 32 +++
 rtl/surf_wr_reloc.sv | 36 +++
 rtl/surf_layer_sched.sv | 168 ++++++++++++++++
 tb/tb_surf_layer_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/surf_pkg.sv
// Shared state encoding, image geometry and filter-size helper for the SURF layer scheduler.
// Pure declarations: no latency, no flow control.
package surf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SETUP,
        GO,
        WAIT,
        NEXT,
        FINISH
    } state_t;

    localparam int unsigned SURF_COL   = 320;
    localparam int unsigned SURF_ROW   = 240;
    localparam int unsigned LAYER_SIZE = SURF_COL * SURF_ROW;

    localparam logic [5:0] SIZE_BASE = 6'd9;
    localparam logic [5:0] SIZE_STEP = 6'd6;

    // Constant-step adder chain; each layer widens the box filter by one step.
    function automatic logic [5:0] filter_size(input logic [1:0] layer);
        logic [5:0] sz;
        sz = SIZE_BASE;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(layer)) sz = sz + SIZE_STEP;
        end
        return sz;
    endfunction

endpackage

// File: rtl/surf_wr_reloc.sv
// Relocates engine determinant writes into the current layer's region of shared memory.
// Latency: 1 cycle registered; no backpressure, writes outside the open window are dropped.
module surf_wr_reloc #(
    parameter int A_WIDTH  = 17,
    parameter int DA_WIDTH = 19,
    parameter int D_WIDTH  = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Wr_Open,
    input  logic [DA_WIDTH-1:0] DBase,
    input  logic [A_WIDTH-1:0]  Eng_D_Addr,
    input  logic                Eng_O_En,
    input  logic                Eng_O_RW,
    input  logic [D_WIDTH-1:0]  Eng_Surf_Out,
    output logic [DA_WIDTH-1:0] Mem_Addr,
    output logic [D_WIDTH-1:0]  Mem_Data,
    output logic                Mem_We
);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Mem_Addr <= '0;
            Mem_Data <= '0;
            Mem_We   <= 1'b0;
        end else begin
            Mem_We <= Eng_O_En & Eng_O_RW & Wr_Open;
            // Address/data hold outside the window so the memory port stays quiet.
            if (Wr_Open) begin
                Mem_Addr <= DBase + DA_WIDTH'(Eng_D_Addr);
                Mem_Data <= Eng_Surf_Out;
            end
        end
    end

endmodule

// File: rtl/surf_layer_sched.sv
// Runs the determinant engine once per enabled scale layer with per-layer config and a watchdog.
// Latency: Done 6 cycles after Start on an empty mask; no backpressure, Abort wins over everything.
module surf_layer_sched
    import surf_pkg::*;
#(
    parameter int A_WIDTH    = 17,
    parameter int DA_WIDTH   = 19,
    parameter int D_WIDTH    = 16,
    parameter int COL        = SURF_COL,
    parameter int ROW        = SURF_ROW,
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 1048575
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [NUM_LAYERS-1:0] Layer_Mask,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic [1:0]            Cur_Layer,
    output logic                  Eng_Go,
    input  logic                  Eng_Done,
    output logic [5:0]            Eng_Size,
    output logic [5:0]            Eng_Margin,
    output logic [8:0]            Eng_EndI,
    output logic [8:0]            Eng_EndJ,
    output logic [3:0]            Eng_XBase,
    output logic [4:0]            Eng_XYBase,
    input  logic [A_WIDTH-1:0]    Eng_D_Addr,
    input  logic                  Eng_O_En,
    input  logic                  Eng_O_RW,
    input  logic [D_WIDTH-1:0]    Eng_Surf_Out,
    output logic [DA_WIDTH-1:0]   Mem_Addr,
    output logic [D_WIDTH-1:0]    Mem_Data,
    output logic                  Mem_We
);

    localparam int                  WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]     WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [DA_WIDTH-1:0] DB_STEP = DA_WIDTH'(COL * ROW);
    localparam logic [1:0]          LAST    = 2'(NUM_LAYERS - 1);
    localparam logic [8:0]          END_I0  = 9'(ROW + 1);
    localparam logic [8:0]          END_J0  = 9'(COL + 1);

    state_t                  state;
    logic [NUM_LAYERS-1:0]   mask_q;
    logic [1:0]              layer_q;
    logic [DA_WIDTH-1:0]     dbase_q;
    logic [WD_W-1:0]         wd_q;
    logic [5:0]              size_w;
    logic                    wr_open;

    assign size_w  = filter_size(layer_q);
    assign wr_open = (state == WAIT);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            mask_q     <= '0;
            layer_q    <= '0;
            dbase_q    <= '0;
            wd_q       <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            Cur_Layer  <= '0;
            Eng_Go     <= 1'b0;
            Eng_Size   <= '0;
            Eng_Margin <= '0;
            Eng_EndI   <= '0;
            Eng_EndJ   <= '0;
            Eng_XBase  <= '0;
            Eng_XYBase <= '0;
        end else begin
            Eng_Go <= 1'b0;
            Done   <= 1'b0;
            if (Abort && state != IDLE) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            mask_q  <= Layer_Mask;
                            Err     <= 1'b0;
                            Busy    <= 1'b1;
                            layer_q <= '0;
                            dbase_q <= '0;
                            state   <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (mask_q[layer_q]) begin
                            state <= SETUP;
                        end else if (layer_q == LAST) begin
                            state <= FINISH;
                        end else begin
                            layer_q <= layer_q + 2'd1;
                            dbase_q <= dbase_q + DB_STEP;
                        end
                    end
                    SETUP: begin
                        // Config lands a full cycle ahead of the go pulse.
                        Eng_Size   <= size_w;
                        Eng_Margin <= {1'b0, size_w[5:1]};
                        Eng_EndI   <= END_I0 - {3'b000, size_w};
                        Eng_EndJ   <= END_J0 - {3'b000, size_w};
                        Eng_XBase  <= {2'b00, layer_q};
                        Eng_XYBase <= {3'b000, layer_q};
                        Cur_Layer  <= layer_q;
                        state      <= GO;
                    end
                    GO: begin
                        Eng_Go <= 1'b1;
                        wd_q   <= '0;
                        state  <= WAIT;
                    end
                    WAIT: begin
                        if (Eng_Done) begin
                            state <= NEXT;
                        end else if (wd_q == WD_MAX) begin
                            Err   <= 1'b1;
                            state <= FINISH;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                    NEXT: begin
                        if (layer_q == LAST) begin
                            state <= FINISH;
                        end else begin
                            layer_q <= layer_q + 2'd1;
                            dbase_q <= dbase_q + DB_STEP;
                            state   <= SCAN;
                        end
                    end
                    FINISH: begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    surf_wr_reloc #(
        .A_WIDTH  (A_WIDTH),
        .DA_WIDTH (DA_WIDTH),
        .D_WIDTH  (D_WIDTH)
    ) u_wr_reloc (
        .Clk          (Clk),
        .Rst          (Rst),
        .Wr_Open      (wr_open),
        .DBase        (dbase_q),
        .Eng_D_Addr   (Eng_D_Addr),
        .Eng_O_En     (Eng_O_En),
        .Eng_O_RW     (Eng_O_RW),
        .Eng_Surf_Out (Eng_Surf_Out),
        .Mem_Addr     (Mem_Addr),
        .Mem_Data     (Mem_Data),
        .Mem_We       (Mem_We)
    );

endmodule

// File: tb/tb_surf_layer_sched.sv
// Scoreboard bench for surf_layer_sched: stimulus queues expected Go/write/Done events,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_surf_layer_sched;

    localparam logic [1:0] K_GO   = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  layer;
        logic [5:0]  size;
        logic [5:0]  margin;
        logic [8:0]  endi;
        logic [8:0]  endj;
        logic [18:0] addr;
        logic [15:0] data;
        logic        err;
    } ev_t;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        Abort;
    logic [3:0]  Layer_Mask;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [1:0]  Cur_Layer;
    logic        Eng_Go;
    logic        Eng_Done;
    logic [5:0]  Eng_Size;
    logic [5:0]  Eng_Margin;
    logic [8:0]  Eng_EndI;
    logic [8:0]  Eng_EndJ;
    logic [3:0]  Eng_XBase;
    logic [4:0]  Eng_XYBase;
    logic [16:0] Eng_D_Addr;
    logic        Eng_O_En;
    logic        Eng_O_RW;
    logic [15:0] Eng_Surf_Out;
    logic [18:0] Mem_Addr;
    logic [15:0] Mem_Data;
    logic        Mem_We;

    int  n_cmp;
    int  n_fail;
    ev_t exp_q[$];

    surf_layer_sched #(
        .A_WIDTH    (17),
        .DA_WIDTH   (19),
        .D_WIDTH    (16),
        .COL        (320),
        .ROW        (240),
        .NUM_LAYERS (4),
        .TIMEOUT    (100)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Start        (Start),
        .Abort        (Abort),
        .Layer_Mask   (Layer_Mask),
        .Busy         (Busy),
        .Done         (Done),
        .Err          (Err),
        .Cur_Layer    (Cur_Layer),
        .Eng_Go       (Eng_Go),
        .Eng_Done     (Eng_Done),
        .Eng_Size     (Eng_Size),
        .Eng_Margin   (Eng_Margin),
        .Eng_EndI     (Eng_EndI),
        .Eng_EndJ     (Eng_EndJ),
        .Eng_XBase    (Eng_XBase),
        .Eng_XYBase   (Eng_XYBase),
        .Eng_D_Addr   (Eng_D_Addr),
        .Eng_O_En     (Eng_O_En),
        .Eng_O_RW     (Eng_O_RW),
        .Eng_Surf_Out (Eng_Surf_Out),
        .Mem_Addr     (Mem_Addr),
        .Mem_Data     (Mem_Data),
        .Mem_We       (Mem_We)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic ev_t ev_go(input int l, input int sz, input int mg, input int ei, input int ej);
        ev_t e;
        e = '{kind: K_GO, layer: 2'(l), size: 6'(sz), margin: 6'(mg), endi: 9'(ei), endj: 9'(ej),
              addr: '0, data: '0, err: 1'b0};
        return e;
    endfunction

    function automatic ev_t ev_wr(input int a, input logic [15:0] d);
        ev_t e;
        e = '{kind: K_WR, layer: '0, size: '0, margin: '0, endi: '0, endj: '0,
              addr: 19'(a), data: d, err: 1'b0};
        return e;
    endfunction

    function automatic ev_t ev_done(input logic er);
        ev_t e;
        e = '{kind: K_DONE, layer: '0, size: '0, margin: '0, endi: '0, endj: '0,
              addr: '0, data: '0, err: er};
        return e;
    endfunction

    task automatic take(input logic [1:0] kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got event kind %0d, want none", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        if (e.kind != kind) return;
        case (kind)
            K_GO: begin
                chk("go_size",      32'(Eng_Size),   32'(e.size));
                chk("go_margin",    32'(Eng_Margin), 32'(e.margin));
                chk("go_endi",      32'(Eng_EndI),   32'(e.endi));
                chk("go_endj",      32'(Eng_EndJ),   32'(e.endj));
                chk("go_cur_layer", 32'(Cur_Layer),  32'(e.layer));
                chk("go_xbase",     32'(Eng_XBase),  32'(e.layer));
                chk("go_xybase",    32'(Eng_XYBase), 32'(e.layer));
            end
            K_WR: begin
                chk("wr_addr", 32'(Mem_Addr), 32'(e.addr));
                chk("wr_data", 32'(Mem_Data), 32'(e.data));
            end
            default: chk("done_err", 32'(Err), 32'(e.err));
        endcase
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            if (Eng_Go) take(K_GO);
            if (Mem_We) take(K_WR);
            if (Done)   take(K_DONE);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_scan(input logic [3:0] mask);
        Layer_Mask = mask;
        Start      = 1'b1;
        tick();
        Start      = 1'b0;
    endtask

    task automatic wait_go(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (Eng_Go) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Returns the number of edges until Busy falls, counted from the cycle after Start.
    task automatic wait_idle(input string name, input int budget, output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cyc++;
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic eng_done_pulse();
        Eng_Done = 1'b1;
        tick();
        Eng_Done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        n_cmp        = 0;
        n_fail       = 0;
        Rst          = 1'b0;
        Start        = 1'b0;
        Abort        = 1'b0;
        Layer_Mask   = '0;
        Eng_Done     = 1'b0;
        Eng_D_Addr   = '0;
        Eng_O_En     = 1'b0;
        Eng_O_RW     = 1'b0;
        Eng_Surf_Out = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy",  32'(Busy), 32'd0);
        chk("rst_flags", 32'({Done, Err, Eng_Go, Mem_We}), 32'd0);
        chk("rst_cfg",   32'({Eng_Size, Eng_Margin, Eng_EndI, Eng_EndJ}), 32'd0);
        chk("rst_mem",   32'(Mem_Addr) | 32'(Mem_Data), 32'd0);
        Rst = 1'b1;
        tick();

        // All four layers, engine answers 50 cycles after each Go; a stray Start is ignored.
        exp_q.push_back(ev_go(0,  9,  4, 232, 312));
        exp_q.push_back(ev_go(1, 15,  7, 226, 306));
        exp_q.push_back(ev_go(2, 21, 10, 220, 300));
        exp_q.push_back(ev_go(3, 27, 13, 214, 294));
        exp_q.push_back(ev_done(1'b0));
        start_scan(4'b1111);
        for (int l = 0; l < 4; l++) begin
            wait_go("t1_go_seen");
            for (int i = 0; i < 49; i++) begin
                Start      = (l == 1 && i == 10);
                Layer_Mask = (l == 1) ? 4'b0000 : 4'b1111;
                tick();
            end
            Start = 1'b0;
            eng_done_pulse();
        end
        wait_idle("t1_finished", 50, cyc);
        tick();
        chk("t1_err", 32'(Err), 32'd0);

        // Single layer 2, one relocated write; mask changes after Start are ignored.
        exp_q.push_back(ev_go(2, 21, 10, 220, 300));
        exp_q.push_back(ev_wr(154885, 16'h1234));
        exp_q.push_back(ev_done(1'b0));
        start_scan(4'b0100);
        Layer_Mask = 4'b1111;
        wait_go("t2_go_seen");
        tick();
        Eng_D_Addr   = 17'd1285;
        Eng_Surf_Out = 16'h1234;
        Eng_O_En     = 1'b1;
        Eng_O_RW     = 1'b1;
        tick();
        chk("t2_we_latency", 32'(Mem_We), 32'd1);
        Eng_O_RW   = 1'b0;
        Eng_D_Addr = 17'd99;
        tick();
        Eng_O_En = 1'b0;
        tick();
        eng_done_pulse();
        wait_idle("t2_finished", 50, cyc);
        tick();

        // Empty mask: Done on the sixth cycle counting the Start cycle as zero.
        exp_q.push_back(ev_done(1'b0));
        start_scan(4'b0000);
        wait_idle("t3_finished", 20, cyc);
        chk("t3_done_cycle", 32'(cyc + 1), 32'd6);
        chk("t3_done_high", 32'(Done), 32'd1);
        tick();

        // Silent engine trips the watchdog; remaining layers are skipped.
        exp_q.push_back(ev_go(0, 9, 4, 232, 312));
        exp_q.push_back(ev_done(1'b1));
        start_scan(4'b1111);
        wait_idle("t4_finished", 300, cyc);
        chk("t4_done_cycle_in_window", 32'((cyc + 1 >= 100) && (cyc + 1 <= 110)), 32'd1);
        tick();
        chk("t4_err_sticky", 32'(Err), 32'd1);
        exp_q.push_back(ev_done(1'b0));
        start_scan(4'b0000);
        chk("t4_err_cleared", 32'(Err), 32'd0);
        wait_idle("t4_rerun_finished", 20, cyc);
        tick();

        // Abort two cycles after the second Go; later engine activity must be ignored.
        exp_q.push_back(ev_go(0,  9, 4, 232, 312));
        exp_q.push_back(ev_go(1, 15, 7, 226, 306));
        start_scan(4'b1111);
        wait_go("t5_go0_seen");
        repeat (4) tick();
        eng_done_pulse();
        wait_go("t5_go1_seen");
        tick();
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("t5_busy_after_abort", 32'(Busy), 32'd0);
        Eng_Done   = 1'b1;
        Eng_O_En   = 1'b1;
        Eng_O_RW   = 1'b1;
        Eng_D_Addr = 17'd5;
        tick();
        Eng_Done = 1'b0;
        repeat (2) tick();
        Eng_O_En = 1'b0;
        Eng_O_RW = 1'b0;
        repeat (20) tick();
        chk("t5_still_idle", 32'(Busy), 32'd0);

        // Asynchronous reset in the middle of WAIT, then a clean run from layer 0.
        exp_q.push_back(ev_go(0, 9, 4, 232, 312));
        exp_q.push_back(ev_wr(7, 16'hBEEF));
        start_scan(4'b1111);
        wait_go("t6_go_seen");
        tick();
        Eng_D_Addr   = 17'd7;
        Eng_Surf_Out = 16'hBEEF;
        Eng_O_En     = 1'b1;
        Eng_O_RW     = 1'b1;
        tick();
        Eng_O_En = 1'b0;
        Eng_O_RW = 1'b0;
        tick();
        #2;
        Rst = 1'b0;
        #1;
        chk("t6_busy_async", 32'(Busy), 32'd0);
        chk("t6_cfg_async",  32'({Eng_Size, Eng_Margin, Eng_EndI, Eng_EndJ}), 32'd0);
        chk("t6_mem_async",  32'(Mem_Addr) | 32'(Mem_Data), 32'd0);
        chk("t6_layer_async", 32'({Cur_Layer, Eng_XBase, Eng_XYBase}), 32'd0);
        tick();
        Rst = 1'b1;
        tick();
        exp_q.push_back(ev_go(0, 9, 4, 232, 312));
        exp_q.push_back(ev_done(1'b0));
        start_scan(4'b0001);
        wait_go("t6_restart_go_seen");
        repeat (2) tick();
        eng_done_pulse();
        wait_idle("t6_restart_finished", 20, cyc);
        tick();
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
